pattern_scanner: RTL and testbench
==================================

Name: pattern_scanner

Overview:
- Parametrised N-digit seven-segment pattern animator with an integrated multiplexed display driver.
- Moves a single lit pattern across NUM_DIGITS digits. Supports bounce, wrap and blink modes, pause with single-step, and display mirroring.
- Replaces the fixed 4-digit bouncer plus external digit switcher at the top level of the pattern displayer; connects directly to board cathodes/anodes.

Parameters:
- NUM_DIGITS, 4, number of digits; legal range 2..16.
- STEP_DIV, 100000000, clk cycles per animation step; at least 2.
- SCAN_DIV, 100000, clk cycles each digit is driven during multiplexing; at least 1.
- UP_PAT, 8'b00111001, active-low segment pattern in phase UP.
- DOWN_PAT, 8'b11000101, active-low segment pattern in phase DOWN.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  1 = logical digit k on physical digit k; 0 = mirrored, logical k on physical NUM_DIGITS-1-k.
- pause  input  1  1 freezes the animation state.
- step_now  input  1  one-cycle pulse; advances one step while pause=1; ignored while pause=0.
- mode  input  2  00 bounce, 01 wrap-up, 10 wrap-down, 11 blink.
- cathodes  output  8  active-low segments, registered.
- anodes  output  NUM_DIGITS  active-low one-hot digit enable, registered.
- pos  output  clog2(NUM_DIGITS)  current logical position.
- phase  output  1  0 = UP, 1 = DOWN.

Behaviour:
- Reset (async assert, sync release): pos=0, phase=UP, visible=1, step counter=0, scan counter=0, sel=0, anodes=all ones, cathodes=8'hFF.
- Step counter: counts 0..STEP_DIV-1 and wraps. tick=1 for one cycle when count==STEP_DIV-1. The counter always runs, including during pause.
- adv = (tick & ~pause) | (step_now & pause). A tick and step_now in the same cycle with pause=1 give one advance, not two.
- On adv, by mode:
  - bounce, phase UP: if pos==N-1 then phase<=DOWN and pos holds (one-step dwell); else pos+1.
  - bounce, phase DOWN: if pos==0 then phase<=UP and pos holds; else pos-1.
  - wrap-up: phase<=UP; pos<=(pos==N-1)?0:pos+1.
  - wrap-down: phase<=DOWN; pos<=(pos==0)?N-1:pos-1.
  - blink: pos and phase hold; visible toggles.
- visible is forced to 1 on any adv in a non-blink mode.
- A mode change takes effect at the next adv. No state changes on the mode change itself.
- Logical digit contents are combinational from the registered state:
  - digit pos = (phase ? DOWN_PAT : UP_PAT) when visible=1, else 8'hFF.
  - all other digits = 8'hFF.
  - Zero-step lag: the pattern changes in the same cycle pos changes.
- Scan:
  - Scan counter counts 0..SCAN_DIV-1. On wrap, sel<=(sel==N-1)?0:sel+1.
  - Each cycle: anodes<=~(1<<sel); cathodes<=logical digit (en ? sel : N-1-sel).
  - Outputs lag sel by one clk.
  - First active anodes/cathodes appear one clk after reset release.
- en and pause are sampled every clk with no synchroniser inside the block; they are the caller's responsibility.
- Reset mid-step or mid-scan: every register returns immediately to its reset value, regardless of clock.
- Anodes are always exactly one-hot-low after the first post-reset cycle. They are never all-low or multi-low.

Test Plan:
- N=4, STEP_DIV=4, SCAN_DIV=1, mode=00, run 10 steps -> pos/phase sequence 1U,2U,3U,3D,2D,1D,0D,0U,1U,2U.
- N=4, mode=01 from reset, 5 steps -> pos 1,2,3,0,1, phase=0. Switch to mode=10 -> next steps give pos 0,3, phase=1.
- pause=1 across 3 ticks -> pos unchanged. step_now pulse coincident with a tick -> pos advances by exactly 1.
- en=1, pos=1, phase=UP, scan -> anodes cycle 1110,1101,1011,0111. Cathodes=8'b00111001 only while anodes=1101; with en=0, only while anodes=1011.
- mode=11 at pos=2 -> digit 2 alternates UP_PAT / 8'hFF on each step. Switching to mode=00 -> next adv sets visible=1 and moves pos to 3.
- rst asserted asynchronously mid-step (between clk edges) -> anodes=all ones and cathodes=8'hFF with no clock edge. After release: pos=0, phase=0, first anode 1110 on the next clk.

Source files
------------

// File: rtl/pattern_scanner.sv
// Single-pattern animator across NUM_DIGITS seven-segment digits with an
// integrated multiplexed display driver (bounce, wrap, blink, pause/step, mirror).
module pattern_scanner #(
    parameter int         NUM_DIGITS = 4,
    parameter int         STEP_DIV   = 100000000,
    parameter int         SCAN_DIV   = 100000,
    parameter logic [7:0] UP_PAT     = 8'b00111001,
    parameter logic [7:0] DOWN_PAT   = 8'b11000101
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          pause,
    input  logic                          step_now,
    input  logic [1:0]                    mode,
    output logic [7:0]                    cathodes,
    output logic [NUM_DIGITS-1:0]         anodes,
    output logic [$clog2(NUM_DIGITS)-1:0] pos,
    output logic                          phase
);

    localparam int PW  = $clog2(NUM_DIGITS);
    localparam int SDW = $clog2(STEP_DIV);
    localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_DIGITS - 1);

    typedef enum logic {PH_UP = 1'b0, PH_DOWN = 1'b1} phase_t;
    typedef enum logic [1:0] {
        M_BOUNCE    = 2'b00,
        M_WRAP_UP   = 2'b01,
        M_WRAP_DOWN = 2'b10,
        M_BLINK     = 2'b11
    } mode_t;

    logic [SDW-1:0] step_cnt;
    logic [SW-1:0]  scan_cnt;
    logic [PW-1:0]  sel;
    logic [PW-1:0]  pos_q, pos_d;
    phase_t         phase_q, phase_d;
    logic           vis_q, vis_d;
    logic           tick, adv;
    logic [PW-1:0]  lidx;
    logic [7:0]     digit;

    assign tick  = (step_cnt == SDW'(STEP_DIV - 1));
    // A tick coinciding with step_now while paused still yields a single advance.
    assign adv   = (tick & ~pause) | (step_now & pause);
    assign pos   = pos_q;
    assign phase = phase_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
            pos_q    <= '0;
            phase_q  <= PH_UP;
            vis_q    <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            step_cnt <= tick ? '0 : step_cnt + 1'b1;
            pos_q    <= pos_d;
            phase_q  <= phase_d;
            vis_q    <= vis_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        pos_d   = pos_q;
        phase_d = phase_q;
        vis_d   = vis_q;
        if (adv) begin
            vis_d = 1'b1;
            case (mode_t'(mode))
                M_BOUNCE: begin
                    if (phase_q == PH_UP) begin
                        if (pos_q == LAST) phase_d = PH_DOWN;
                        else               pos_d   = pos_q + 1'b1;
                    end else begin
                        if (pos_q == '0)   phase_d = PH_UP;
                        else               pos_d   = pos_q - 1'b1;
                    end
                end
                M_WRAP_UP: begin
                    phase_d = PH_UP;
                    pos_d   = (pos_q == LAST) ? '0 : pos_q + 1'b1;
                end
                M_WRAP_DOWN: begin
                    phase_d = PH_DOWN;
                    pos_d   = (pos_q == '0) ? LAST : pos_q - 1'b1;
                end
                default: vis_d = ~vis_q;
            endcase
        end
    end

    always_comb begin
        lidx  = en ? sel : LAST - sel;
        digit = 8'hFF;
        if (lidx == pos_q && vis_q)
            digit = (phase_q == PH_DOWN) ? DOWN_PAT : UP_PAT;
    end

    // Outputs are driven from the current sel, so they trail sel by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            sel      <= '0;
            anodes   <= '1;
            cathodes <= 8'hFF;
        end else begin
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                sel      <= (sel == LAST) ? '0 : sel + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            anodes   <= ~(NUM_DIGITS'(1) << sel);
            cathodes <= digit;
        end
    end

endmodule

// File: tb/tb_pattern_scanner.sv
// Directed bench for pattern_scanner: N=4, STEP_DIV=4, SCAN_DIV=1, so one
// animation step every 4 clocks and the scan select advancing every clock.
module tb_pattern_scanner;

    localparam logic [7:0] UP   = 8'b00111001;
    localparam logic [7:0] DOWN = 8'b11000101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       pause = 1'b0;
    logic       step_now = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] cathodes;
    logic [3:0] anodes;
    logic [1:0] pos;
    logic       phase;

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;

    pattern_scanner #(
        .NUM_DIGITS(4), .STEP_DIV(4), .SCAN_DIV(1),
        .UP_PAT(UP), .DOWN_PAT(DOWN)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pause(pause), .step_now(step_now),
        .mode(mode), .cathodes(cathodes), .anodes(anodes), .pos(pos), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc_cnt++;
        end
        #1;
    endtask

    task automatic pulse();
        step_now = 1'b1;
        cyc(1);
        step_now = 1'b0;
    endtask

    task automatic state_chk(input string tag, input int p, input bit ph);
        chk({tag, "_pos"}, 32'(pos), 32'(p));
        chk({tag, "_phase"}, 32'(phase), 32'(ph));
    endtask

    // Four scan clocks; the edge numbered k drives the digit selected by (k-1)%4.
    task automatic scan_chk(input string tag, input int p, input bit ph, input bit vis);
        int s, l;
        logic [3:0] ea;
        logic [7:0] ec;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            s  = (cyc_cnt - 1) % 4;
            l  = en ? s : 3 - s;
            ea = ~(4'b0001 << s);
            ec = (l == p && vis) ? (ph ? DOWN : UP) : 8'hFF;
            chk({tag, "_an"}, 32'(anodes), 32'(ea));
            chk({tag, "_cat"}, 32'(cathodes), 32'(ec));
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        cyc_cnt = 0;
        cyc(1);
        chk("first_an", 32'(anodes), 32'h0000000E);
        chk("first_cat", 32'(cathodes), 32'(UP));
        cyc(3);
    endtask

    int bounce_pos[10] = '{1, 2, 3, 3, 2, 1, 0, 0, 1, 2};
    bit bounce_ph[10]  = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    int wrap_pos[5]    = '{1, 2, 3, 0, 1};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_an", 32'(anodes), 32'h0000000F);
        chk("rst_cat", 32'(cathodes), 32'h000000FF);
        state_chk("rst", 0, 1'b0);

        // Bounce: release_rst leaves us right after the first advance.
        release_rst();
        state_chk("bounce0", bounce_pos[0], bounce_ph[0]);
        for (int i = 1; i < 10; i++) begin
            cyc(4);
            state_chk($sformatf("bounce%0d", i), bounce_pos[i], bounce_ph[i]);
        end

        // Asynchronous reset between clock edges.
        #3 rst = 1'b1;
        #1;
        chk("async_an", 32'(anodes), 32'h0000000F);
        chk("async_cat", 32'(cathodes), 32'h000000FF);
        state_chk("async", 0, 1'b0);

        // Wrap-up from reset, then wrap-down.
        mode = 2'b01;
        release_rst();
        state_chk("wrapup0", wrap_pos[0], 1'b0);
        for (int i = 1; i < 5; i++) begin
            cyc(4);
            state_chk($sformatf("wrapup%0d", i), wrap_pos[i], 1'b0);
        end
        mode = 2'b10;
        cyc(4);
        state_chk("wrapdn0", 0, 1'b1);
        cyc(4);
        state_chk("wrapdn1", 3, 1'b1);

        // step_now without pause is ignored; the regular tick still advances.
        step_now = 1'b1;
        cyc(1);
        step_now = 1'b0;
        state_chk("stepign", 3, 1'b1);
        cyc(3);
        state_chk("tickadv", 2, 1'b1);

        // Pause across three ticks, then step_now coincident with a tick.
        pause = 1'b1;
        cyc(12);
        state_chk("paused", 2, 1'b1);
        cyc(3);
        pulse();
        state_chk("coincide", 1, 1'b1);

        // Reach pos=1 UP with single steps, then check scan with and without mirroring.
        mode = 2'b01;
        repeat (4) pulse();
        state_chk("stepped", 1, 1'b0);
        scan_chk("scan_en1", 1, 1'b0, 1'b1);
        en = 1'b0;
        cyc(1);
        scan_chk("scan_en0", 1, 1'b0, 1'b1);
        en = 1'b1;

        // Blink at pos=2, then back to bounce.
        pulse();
        state_chk("blinkpos", 2, 1'b0);
        mode = 2'b11;
        pulse();
        scan_chk("blink_off0", 2, 1'b0, 1'b0);
        pulse();
        scan_chk("blink_on", 2, 1'b0, 1'b1);
        pulse();
        state_chk("blink_hold", 2, 1'b0);
        scan_chk("blink_off1", 2, 1'b0, 1'b0);
        mode = 2'b00;
        pulse();
        state_chk("unblink", 3, 1'b0);
        scan_chk("unblink", 3, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
